// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU global header: control-op and exception encodings,
// control register indices and widths, and write-truncation helpers.
package pipe_ctrl_pkg;

    localparam int XLEN  = 32;
    localparam int PC_W  = 30;
    localparam int CR_AW = 5;
    localparam int IRQ_W = 8;

    typedef enum logic [1:0] {
        CTRL_NOP  = 2'd0,
        CTRL_WRCR = 2'd1,
        CTRL_EXRT = 2'd2
    } ctrl_op_e;

    typedef enum logic [2:0] {
        EXP_NONE     = 3'd0,
        EXP_EXT_INT  = 3'd1,
        EXP_UNDEF    = 3'd2,
        EXP_OVERFLOW = 3'd3,
        EXP_MISALIGN = 3'd4,
        EXP_TRAP     = 3'd5,
        EXP_PRV_VIO  = 3'd6
    } exp_code_e;

    localparam logic [CR_AW-1:0] CR_STATUS     = 5'd0;
    localparam logic [CR_AW-1:0] CR_PRE_STATUS = 5'd1;
    localparam logic [CR_AW-1:0] CR_INT_MASK   = 5'd2;
    localparam logic [CR_AW-1:0] CR_INT_CAUSE  = 5'd3;
    localparam logic [CR_AW-1:0] CR_EXP_VECTOR = 5'd4;
    localparam logic [CR_AW-1:0] CR_EPC        = 5'd5;
    localparam logic [CR_AW-1:0] CR_EXP_INFO   = 5'd6;

    function automatic logic creg_wr_ok(input logic [CR_AW-1:0] idx);
        return (idx <= CR_EXP_INFO) && (idx != CR_INT_CAUSE);
    endfunction

    // Value a write of d to idx would read back as.
    function automatic logic [XLEN-1:0] creg_trunc(
        input logic [CR_AW-1:0] idx,
        input logic [XLEN-1:0]  d
    );
        logic [XLEN-1:0] r;
        r = '0;
        case (idx)
            CR_STATUS, CR_PRE_STATUS: r = {30'b0, d[1:0]};
            CR_INT_MASK:              r = {24'b0, d[7:0]};
            CR_EXP_VECTOR, CR_EPC:    r = {2'b0, d[29:0]};
            CR_EXP_INFO:              r = {28'b0, d[3:0]};
            default:                  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_creg_file.sv
// Control register file: irq synchronizer, exception capture,
// EXRT restore, WRCR writes and same-cycle read forwarding.
module creg_file
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [IRQ_W-1:0] irq,
    input  logic             wr_en,
    input  logic [CR_AW-1:0] wr_addr,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             exp_take,
    input  logic [PC_W-1:0]  exp_pc,
    input  logic             exp_dly,
    input  logic [2:0]       exp_code,
    input  logic             exrt,
    input  logic [CR_AW-1:0] rd_addr,
    output logic [XLEN-1:0]  rd_data,
    output logic [1:0]       status,
    output logic [IRQ_W-1:0] int_mask,
    output logic [IRQ_W-1:0] int_cause,
    output logic [PC_W-1:0]  exp_vector,
    output logic [PC_W-1:0]  epc
);

    logic [1:0]       status_q, status_d;
    logic [1:0]       pre_status_q, pre_status_d;
    logic [IRQ_W-1:0] int_mask_q, int_mask_d;
    logic [IRQ_W-1:0] int_cause_q, int_cause_d;
    logic [IRQ_W-1:0] irq_s1_q, irq_s1_d;
    logic [IRQ_W-1:0] irq_s2_q, irq_s2_d;
    logic [PC_W-1:0]  exp_vector_q, exp_vector_d;
    logic [PC_W-1:0]  epc_q, epc_d;
    logic [3:0]       exp_info_q, exp_info_d;
    logic             wr_ok;

    assign wr_ok = wr_en && creg_wr_ok(wr_addr);

    always_comb begin
        status_d     = status_q;
        pre_status_d = pre_status_q;
        int_mask_d   = int_mask_q;
        exp_vector_d = exp_vector_q;
        epc_d        = epc_q;
        exp_info_d   = exp_info_q;
        irq_s1_d     = irq;
        irq_s2_d     = irq_s1_q;
        int_cause_d  = irq_s2_q;
        if (exp_take) begin
            epc_d        = exp_dly ? exp_pc - 30'd1 : exp_pc;
            exp_info_d   = {exp_dly, exp_code};
            pre_status_d = status_q;
            status_d     = 2'b00;
        end else if (exrt) begin
            status_d = pre_status_q;
        end else if (wr_ok) begin
            case (wr_addr)
                CR_STATUS:     status_d     = wr_data[1:0];
                CR_PRE_STATUS: pre_status_d = wr_data[1:0];
                CR_INT_MASK:   int_mask_d   = wr_data[7:0];
                CR_EXP_VECTOR: exp_vector_d = wr_data[29:0];
                CR_EPC:        epc_d        = wr_data[29:0];
                CR_EXP_INFO:   exp_info_d   = wr_data[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q     <= '0;
            pre_status_q <= '0;
            int_mask_q   <= '1;
            int_cause_q  <= '0;
            irq_s1_q     <= '0;
            irq_s2_q     <= '0;
            exp_vector_q <= '0;
            epc_q        <= '0;
            exp_info_q   <= '0;
        end else begin
            status_q     <= status_d;
            pre_status_q <= pre_status_d;
            int_mask_q   <= int_mask_d;
            int_cause_q  <= int_cause_d;
            irq_s1_q     <= irq_s1_d;
            irq_s2_q     <= irq_s2_d;
            exp_vector_q <= exp_vector_d;
            epc_q        <= epc_d;
            exp_info_q   <= exp_info_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            CR_STATUS:     rd_data = {30'b0, status_q};
            CR_PRE_STATUS: rd_data = {30'b0, pre_status_q};
            CR_INT_MASK:   rd_data = {24'b0, int_mask_q};
            CR_INT_CAUSE:  rd_data = {24'b0, int_cause_q};
            CR_EXP_VECTOR: rd_data = {2'b0, exp_vector_q};
            CR_EPC:        rd_data = {2'b0, epc_q};
            CR_EXP_INFO:   rd_data = {28'b0, exp_info_q};
            default:       rd_data = '0;
        endcase
        if (wr_ok && wr_addr == rd_addr)
            rd_data = creg_trunc(rd_addr, wr_data);
    end

    assign status     = status_q;
    assign int_mask   = int_mask_q;
    assign int_cause  = int_cause_q;
    assign exp_vector = exp_vector_q;
    assign epc        = epc_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/flush arbitration, exception and EXRT
// redirects, and interrupt detection over the control register file.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             if_busy,
    input  logic             ld_hazard,
    input  logic             mem_busy,
    input  logic [IRQ_W-1:0] irq,
    input  logic [PC_W-1:0]  mem_pc,
    input  logic             mem_en,
    input  logic             mem_br_flag,
    input  logic [1:0]       mem_ctrl_op,
    input  logic [CR_AW-1:0] mem_dst_addr,
    input  logic [2:0]       mem_exp_code,
    input  logic [XLEN-1:0]  mem_out,
    input  logic [CR_AW-1:0] creg_rd_addr,
    output logic [XLEN-1:0]  creg_rd_data,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic [PC_W-1:0]  new_pc,
    output logic             br_flag,
    output logic             int_detect,
    output logic             exe_mode
);

    logic [1:0]       status;
    logic [IRQ_W-1:0] int_mask;
    logic [IRQ_W-1:0] int_cause;
    logic [PC_W-1:0]  exp_vector;
    logic [PC_W-1:0]  epc;
    logic             exp_hit, exrt_hit, wrcr_hit;
    logic             exp_take, exrt_take, wr_en;

    assign exp_hit  = mem_en && (mem_exp_code != EXP_NONE);
    assign exrt_hit = mem_en && (mem_ctrl_op == CTRL_EXRT);
    assign wrcr_hit = mem_en && (mem_ctrl_op == CTRL_WRCR);

    always_comb begin
        {if_stall, id_stall, ex_stall, mem_stall} = 4'b0;
        {if_flush, id_flush, ex_flush, mem_flush} = 4'b0;
        new_pc    = '0;
        br_flag   = 1'b0;
        exp_take  = 1'b0;
        exrt_take = 1'b0;
        wr_en     = 1'b0;
        priority case (1'b1)
            !reset: ;
            mem_busy: begin
                {if_stall, id_stall, ex_stall, mem_stall} = 4'hF;
            end
            exp_hit: begin
                {if_flush, id_flush, ex_flush, mem_flush} = 4'hF;
                new_pc   = exp_vector;
                br_flag  = 1'b1;
                exp_take = 1'b1;
            end
            exrt_hit: begin
                {if_flush, id_flush, ex_flush, mem_flush} = 4'hF;
                new_pc    = epc;
                br_flag   = 1'b1;
                exrt_take = 1'b1;
            end
            default: begin
                // WRCR has no pipeline effect, so hazards still apply.
                wr_en = wrcr_hit;
                if (ld_hazard) begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    ex_flush = 1'b1;
                end else if (if_busy) begin
                    if_stall = 1'b1;
                    id_flush = 1'b1;
                end
            end
        endcase
    end

    creg_file u_creg (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .wr_en      (wr_en),
        .wr_addr    (mem_dst_addr),
        .wr_data    (mem_out),
        .exp_take   (exp_take),
        .exp_pc     (mem_pc),
        .exp_dly    (mem_br_flag),
        .exp_code   (mem_exp_code),
        .exrt       (exrt_take),
        .rd_addr    (creg_rd_addr),
        .rd_data    (creg_rd_data),
        .status     (status),
        .int_mask   (int_mask),
        .int_cause  (int_cause),
        .exp_vector (exp_vector),
        .epc        (epc)
    );

    assign int_detect = status[1] & |(int_cause & ~int_mask);
    assign exe_mode   = status[0];

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  clock
- reset  in  1  async active-low reset
- if_busy  in  1  fetch bus wait
- ld_hazard  in  1  load-use hazard from decoder
- mem_busy  in  1  data bus wait
- irq  in  8  external interrupt lines, asynchronous
- mem_pc  in  30  MEM-stage word PC
- mem_en  in  1  MEM-stage valid
- mem_br_flag  in  1  MEM instruction sits in a delay slot
- mem_ctrl_op  in  2  0 NOP, 1 WRCR, 2 EXRT
- mem_dst_addr  in  5  control register index
- mem_exp_code  in  3  0 none, 1 EXT_INT, 2 UNDEF, 3 OVERFLOW, 4 MISALIGN, 5 TRAP, 6 PRV_VIO
- mem_out  in  32  write data for WRCR
- creg_rd_addr  in  5  read index
- creg_rd_data  out  32  combinational read
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  stage holds
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  stage bubbles
- new_pc  out  30  redirect target, valid with if_flush
- br_flag  out  1  redirect is taken
- int_detect  out  1  unmasked pending interrupt
- exe_mode  out  1  0 kernel, 1 user

Function
REQ-003 Control registers SHALL be: 0 STATUS{int_en[1], mode[0]}, 1 PRE_STATUS, 2 INT_MASK[7:0] (1=masked), 3 INT_CAUSE[7:0], 4 EXP_VECTOR[29:0], 5 EPC[29:0], 6 EXP_INFO{dly[3], code[2:0]}; all other indices read 0.
REQ-004 irq SHALL pass a 2-flop synchronizer; INT_CAUSE SHALL equal the synchronized irq, updated every cycle.
REQ-005 int_detect SHALL equal int_en AND OR(INT_CAUSE AND NOT INT_MASK).
REQ-006 mem_busy SHALL assert all four stalls.
REQ-007 ld_hazard with mem_busy=0 SHALL assert if_stall and id_stall and ex_flush.
REQ-008 if_busy with mem_busy=0 and ld_hazard=0 SHALL assert if_stall and id_flush.
REQ-009 Exception: mem_en=1, mem_exp_code!=0, mem_busy=0 SHALL assert all four flushes, no stalls, new_pc=EXP_VECTOR, br_flag=1 in the same cycle.
REQ-010 At that edge: EPC SHALL take mem_pc-1 if mem_br_flag else mem_pc; EXP_INFO SHALL take {mem_br_flag, mem_exp_code}; PRE_STATUS SHALL take STATUS; STATUS SHALL become {0,0}.
REQ-011 EXRT (mem_en=1, no exception, mem_busy=0) SHALL flush all stages, drive new_pc=EPC and br_flag=1, and restore STATUS from PRE_STATUS.
REQ-012 WRCR (mem_en=1, no exception, mem_busy=0) SHALL write mem_out into register mem_dst_addr at the edge; writes to indices 3 and 7-31 SHALL be ignored; writes SHALL be truncated to register width.
REQ-013 Priority SHALL be: mem_busy stall > exception > EXRT/WRCR > ld_hazard > if_busy.
REQ-014 Any of REQ-009/011/012 while mem_busy=1 SHALL be deferred with no state change, because MEM holds.
REQ-015 creg_rd_data SHALL forward a same-cycle WRCR to the same index.
REQ-016 exe_mode SHALL equal STATUS.mode.

Reset
REQ-017 Reset SHALL clear STATUS, PRE_STATUS, INT_CAUSE, EPC, EXP_INFO, EXP_VECTOR and the synchronizer flops, and set INT_MASK=8'hFF.
REQ-018 During reset, every stall and flush output SHALL be 0; new_pc, br_flag and int_detect SHALL be 0; exe_mode SHALL be 0 (kernel).
REQ-019 Reset asserted mid-exception SHALL discard the capture and leave the reset values.

Structure
REQ-020 The ctrl_op encodings, exception codes, register indices and widths SHALL reside in the shared CPU global header.
REQ-021 The control register file with forwarding SHALL be a sub-module named creg_file; the stall/flush logic SHALL stay in pipe_ctrl.

Verification
REQ-022 Bench SHALL cover:
- reset release -> all outputs 0, INT_MASK reads 8'hFF.
- WRCR idx2 data 0x0000_00FE, then STATUS=0x2, irq[0] pulsed -> int_detect=1 three cycles after irq rises.
- mem_exp_code=3, mem_pc=0x100, mem_br_flag=1, EXP_VECTOR=0x40 -> all flushes=1, new_pc=0x40; next cycle EPC=0xFF, EXP_INFO=0xB, STATUS=0.
- EXRT with EPC=0x200, PRE_STATUS=0x3 -> new_pc=0x200, all flushes; next cycle exe_mode=1.
- mem_busy=1 with an exception for 3 cycles -> all stalls, no capture; capture occurs in the cycle mem_busy falls.
- ld_hazard and if_busy together -> if_stall=1, id_stall=1, ex_flush=1, id_flush=0.
